// File: rtl/cdm8_73_approx_mult.sv
// Registered carry-disregard approximate multiplier: the low K product columns
// are OR-reduced, the upper columns are summed exactly with no carry-in.
module cdm8_73_approx_mult #(
    parameter int W = 8,
    parameter int K = 7
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    output logic           out_valid,
    output logic [2*W-1:0] R
);

    localparam int HW = 2*W - K;

    logic [W-1:0][2*W-1:0] row;
    logic [W:0][K-1:0]     lo_acc;
    logic [W:0][HW-1:0]    hi_acc;

    logic           out_valid_d, out_valid_q;
    logic [2*W-1:0] r_d, r_q;

    assign lo_acc[0] = '0;
    assign hi_acc[0] = '0;

    // Each shifted row places pp[i][j] in column i+j. OR-ing the rows' low bits
    // gives the per-column OR; summing their upper slices as numbers gives
    // sum(popcount(col c) << (c-K)) with nothing carried in from below.
    for (genvar i = 0; i < W; i++) begin : g_row
        assign row[i]      = {{W{1'b0}}, ({W{A[i]}} & B)} << i;
        assign lo_acc[i+1] = lo_acc[i] | row[i][K-1:0];
        assign hi_acc[i+1] = hi_acc[i] + row[i][2*W-1:K];
    end

    always_comb begin
        out_valid_d = in_valid;
        r_d         = r_q;
        if (in_valid) begin
            r_d = {hi_acc[W], lo_acc[W]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            r_q         <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            r_q         <= r_d;
        end
    end

    assign out_valid = out_valid_q;
    assign R         = r_q;

endmodule

// File: tb/tb_cdm8_73_approx_mult.sv
// Bench for cdm8_73_approx_mult: column-rule reference model checked every cycle,
// directed literal cases, exhaustive operand sweep and a random valid/reset phase.
module tb_cdm8_73_approx_mult;

    localparam int W = 8;
    localparam int K = 7;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic [W-1:0]   A = '0;
    logic [W-1:0]   B = '0;
    logic           out_valid;
    logic [2*W-1:0] R;

    int n_cmp = 0;
    int n_err = 0;

    cdm8_73_approx_mult #(.W(W), .K(K)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B),
        .out_valid(out_valid), .R(R)
    );

    always #5 clk = ~clk;

    // Column rule straight from the definition: count terms per column.
    function automatic int approx(input int a, input int b);
        int cnt [2*W-1];
        int hi;
        int r;
        for (int c = 0; c < 2*W-1; c++) cnt[c] = 0;
        for (int i = 0; i < W; i++)
            for (int j = 0; j < W; j++)
                if (((a >> i) & 1) == 1 && ((b >> j) & 1) == 1) cnt[i+j]++;
        r  = 0;
        hi = 0;
        for (int c = 0; c < 2*W-1; c++) begin
            if (c < K) begin
                if (cnt[c] != 0) r = r | (1 << c);
            end else begin
                hi = hi + (cnt[c] << (c - K));
            end
        end
        return r + (hi << K);
    endfunction

    function automatic bit is_pow2(input int v);
        return v != 0 && (v & (v - 1)) == 0;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Cycle model of the output register.
    bit m_live  = 1'b0;
    bit m_valid = 1'b0;
    int m_r     = 0;
    int m_a     = 0;
    int m_b     = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_live  = 1'b1;
            m_valid = 1'b0;
            m_r     = 0;
        end else begin
            m_valid = in_valid;
            if (in_valid) begin
                m_a = int'(A);
                m_b = int'(B);
                m_r = approx(m_a, m_b);
            end
        end
    end

    // Compare process, sampled on the falling edge.
    always @(negedge clk) begin
        if (m_live) begin
            check("out_valid", int'(out_valid), int'(m_valid));
            check("R_model", int'(R), m_r);
            if (m_valid) begin
                if (int'(R) > m_a * m_b) begin
                    check("R_le_AB", int'(R), m_a * m_b);
                end
                if (is_pow2(m_a) || is_pow2(m_b)) begin
                    check("R_exact_pow2", int'(R), m_a * m_b);
                end
            end
        end
    end

    task automatic drive(input bit v, input int a, input int b);
        in_valid = v;
        A = W'(a);
        B = W'(b);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // model pinned by hand-computed values
        check("model_255x255", approx(255, 255), 64383);
        check("model_3x3", approx(3, 3), 7);
        check("model_15x15", approx(15, 15), 127);
        check("model_128x128", approx(128, 128), 16384);

        // reset with a valid operation pending
        rst = 1'b1;
        drive(1, 255, 255);
        check("rst_R_0", int'(R), 0);
        check("rst_valid_0", int'(out_valid), 0);
        drive(1, 255, 255);
        check("rst_R_1", int'(R), 0);
        check("rst_valid_1", int'(out_valid), 0);
        rst = 1'b0;
        drive(1, 255, 255);
        check("first_R", int'(R), 64383);
        check("first_valid", int'(out_valid), 1);

        // exact and carry-loss cases
        drive(1, 1, 200);   check("1x200", int'(R), 200);
        check("1x200_valid", int'(out_valid), 1);
        drive(1, 128, 128); check("128x128", int'(R), 16384);
        drive(1, 0, 173);   check("0x173", int'(R), 0);
        drive(1, 15, 15);   check("15x15", int'(R), 127);

        // pipelining then hold
        drive(1, 3, 3);     check("pipe_3x3", int'(R), 7);
        drive(1, 1, 200);   check("pipe_1x200", int'(R), 200);
        drive(0, 77, 99);
        check("hold_valid", int'(out_valid), 0);
        check("hold_R", int'(R), 200);

        // exhaustive sweep, one pair per cycle
        for (int a = 0; a < 256; a++)
            for (int b = 0; b < 256; b++)
                drive(1, a, b);

        // random operands, gaps and occasional reset
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 255), $urandom_range(0, 255));
        end
        rst = 1'b0;
        drive(0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
